uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between NUM_REQ byte producers, such as game-state, score and debug senders.
- Grants requesters round-robin and drives the transmitter's data/transmit inputs.
- Times each frame itself with a cycle counter, because the transmitter has no busy/done output.
- Sits between the game logic and uart_tx; tx_data and tx_transmit connect directly to uart_tx's data and transmit ports.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- CLKS_PER_BIT, 10416: clock cycles per UART bit (100 MHz / 9600 baud). Must match uart_tx.
- FRAME_BITS, 10: bits per frame (start + 8 data + stop).
- GAP_CYCLES, 2: idle cycles with tx_transmit low between frames; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  bit i high = requester i has a byte pending
- req_data  in  8*NUM_REQ  byte for requester i is at bits [8i+7:8i]
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- tx_data  out  8  byte presented to uart_tx
- tx_transmit  out  1  transmit enable to uart_tx
- busy  out  1  high whenever the FSM is not in IDLE
- grant_id  out  clog2(NUM_REQ)  index of the last granted requester

Behaviour:
- Reset (synchronous, highest priority, valid in any state):
  - tx_data=0, tx_transmit=0, busy=0, req_ready=0, grant_id=0, FSM=IDLE, frame counter=0.
  - Priority pointer set so requester 0 wins first: last=NUM_REQ-1.
  - Reset mid-frame aborts the byte. tx_transmit is 0 on the first cycle after reset is sampled. The aborted requester gets no second req_ready.
- Handshake:
  - A transfer occurs in the cycle req_valid[i] & req_ready[i].
  - The requester holds req_valid and its req_data stable until req_ready.
  - Dropping req_valid before grant is legal; that byte is never sent.
  - req_ready is one-hot or zero, and never high outside IDLE.
- FSM states:
  - IDLE: if any req_valid is set, select the first set bit searching upward from last+1, with wrap-around modulo NUM_REQ.
    - In the same cycle (combinational from req_valid and the pointer): assert req_ready[winner].
    - Registered on that edge: tx_data <= req_data[winner]; grant_id <= winner; last <= winner; tx_transmit <= 1; busy <= 1; counter <= 0; go to SEND.
    - If no req_valid is set, remain in IDLE with outputs unchanged except req_ready=0.
  - SEND:
    - tx_transmit=1 and tx_data held constant.
    - Counter increments each cycle.
    - When counter == FRAME_BITS*CLKS_PER_BIT-1: tx_transmit <= 0, counter <= 0, go to GAP.
    - tx_transmit is therefore high for exactly FRAME_BITS*CLKS_PER_BIT cycles.
  - GAP:
    - tx_transmit=0 for GAP_CYCLES cycles, then go to IDLE with busy <= 0.
    - tx_data holds the last byte until the next grant.
- Timing and width:
  - Minimum spacing between grants is 1 + FRAME_BITS*CLKS_PER_BIT + GAP_CYCLES cycles.
  - The counter is wide enough for FRAME_BITS*CLKS_PER_BIT; there is no wrap inside SEND.
- Boundary conditions:
  - req_valid changes during SEND or GAP are ignored; arbitration is evaluated only in IDLE.
  - A single continuously valid requester is re-granted every frame.
  - Starvation-free: with all requesters valid, each is granted once per NUM_REQ frames.
  - grant_id is undefined-free: it stays 0 until the first grant.

Test Plan (sim with CLKS_PER_BIT=4, FRAME_BITS=10, GAP_CYCLES=2; frame = 40 cycles, grant period = 43 cycles):
1. Reset held 3 cycles, all req_valid=0 -> all outputs 0; busy stays 0 for 20 idle cycles.
2. req_valid=4'b0100, req_data[23:16]=8'hAA -> at cycle 0 after reset release:
   - req_ready=4'b0100 for exactly 1 cycle;
   - tx_data=8'hAA;
   - tx_transmit high exactly 40 cycles, then low 2 cycles;
   - busy low at cycle 43; grant_id=2.
3. req_valid=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43 -> grants in order 0,1,2,3,0 at 43-cycle spacing; tx_data sequence 10,21,32,43,10.
4. After granting requester 1, set req_valid=4'b1010 -> next grant is 3, then 1; never 1 twice in a row.
5. Reset asserted at cycle 20 of SEND -> tx_transmit=0 and busy=0 on the next cycle. After release, with req_valid=4'b0011, requester 0 is granted first.
6. req_valid[1] pulsed high during SEND and dropped before IDLE -> no req_ready[1]; FSM returns to IDLE and remains idle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ---------------
// Shares one uart_tx transmitter between NUM_REQ byte producers. Requesters
// are granted round-robin. The transmitter has no busy/done output, so this
// block times each frame itself: tx_transmit stays high for
// FRAME_BITS*CLKS_PER_BIT cycles, then low for GAP_CYCLES cycles before the
// next arbitration.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   req_valid    [NUM_REQ]    bit i high = requester i has a byte pending
//   req_data     [8*NUM_REQ]  byte for requester i at bits [8i+7:8i]
//   req_ready    [NUM_REQ]    one-cycle accept pulse to the granted requester
//   tx_data      [8]          byte presented to uart_tx
//   tx_transmit               transmit enable to uart_tx
//   busy                      high whenever the FSM is not in IDLE
//   grant_id     [clog2(NUM_REQ)]  index of the last granted requester

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 10416,
    parameter int FRAME_BITS   = 10,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_transmit,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W         = $clog2(NUM_REQ);
    localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
    localparam int CNT_MAX      = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CNT_W        = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   winner;
    logic              found;

    // Round-robin search: first pending requester strictly after the last
    // winner, wrapping modulo NUM_REQ, so the previous winner comes last.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    // Accept pulse is combinational so the byte is taken in the same cycle
    // the grant is registered. It is held off during reset because reset
    // wins over the grant and the byte would otherwise be lost.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && !reset) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Main FSM. One counter is reused for the frame and the inter-frame gap;
    // it is cleared on every state change so each phase counts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            last        <= ID_W'(NUM_REQ - 1);
            tx_data     <= '0;
            tx_transmit <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        tx_data     <= req_data[{winner, 3'b000} +: 8];
                        grant_id    <= winner;
                        last        <= winner;
                        tx_transmit <= 1'b1;
                        busy        <= 1'b1;
                        counter     <= '0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (counter == CNT_W'(FRAME_CYCLES - 1)) begin
                        tx_transmit <= 1'b0;
                        counter     <= '0;
                        state       <= GAP;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (counter == CNT_W'(GAP_CYCLES - 1)) begin
                        busy    <= 1'b0;
                        counter <= '0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// ------------------
// Self-checking bench for uart_tx_arbiter with a short frame
// (CLKS_PER_BIT=4, FRAME_BITS=10, GAP_CYCLES=2: 40-cycle frame, 43-cycle
// grant period). A reference model predicts each grant from the arbitration
// rules and queues it; a monitor on the falling edge pops predictions and
// compares the handshake and the transmitter-side outputs every cycle.

module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int CLKS_PER_BIT = 4;
    localparam int FRAME_BITS   = 10;
    localparam int GAP_CYCLES   = 2;
    localparam int FRAME        = FRAME_BITS * CLKS_PER_BIT;
    localparam int PERIOD       = 1 + FRAME + GAP_CYCLES;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_transmit;
    logic                 busy;
    logic [1:0]           grant_id;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] data;
    } grant_t;

    grant_t exp_q[$];

    int tests    = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state
    int next_free = 0;
    int last_ptr  = NUM_REQ - 1;
    int model_win;

    // monitor state
    bit                 armed    = 1'b0;
    int                 mon_g    = -1000;
    logic [7:0]         mon_byte = '0;
    int                 mon_id   = 0;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [NUM_REQ-1:0] accepted = '0;
    bit                 due;
    grant_t             cur;

    // requester-side driver state
    logic [NUM_REQ-1:0] v = '0;
    logic [7:0]         d [NUM_REQ];
    bit                 hold    = 1'b0;
    bit                 rand_en = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FRAME_BITS   (FRAME_BITS),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_transmit (tx_transmit),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: the transmitter is free again PERIOD cycles after a
    // grant (or the cycle after reset); when free, the first pending
    // requester after the previous winner is granted.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        if (reset) begin
            next_free = cyc + 1;
            last_ptr  = NUM_REQ - 1;
        end else if (cyc >= next_free && req_valid != '0) begin
            model_win = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (model_win < 0 && req_valid[(last_ptr + k) % NUM_REQ]) begin
                    model_win = (last_ptr + k) % NUM_REQ;
                end
            end
            exp_q.push_back('{cyc: cyc, id: model_win, data: req_data[8*model_win +: 8]});
            last_ptr  = model_win;
            next_free = cyc + PERIOD;
        end
    end

    // Monitor: pops the prediction due this cycle and checks every output.
    // tx_transmit/busy windows and the held byte/id follow from the last
    // predicted grant; reset clears them from the next cycle on.
    always @(negedge clk) begin
        accepted = req_ready;
        if (!armed) begin
            armed = reset;
        end else begin
            exp_rdy = '0;
            due     = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                cur = exp_q.pop_front();
                due = 1'b1;
                exp_rdy[cur.id] = 1'b1;
            end
            check_output("req_ready", 32'(req_ready), 32'(exp_rdy));
            check_output("tx_transmit", 32'(tx_transmit), 32'(cyc >= mon_g + 1 && cyc <= mon_g + FRAME));
            check_output("busy", 32'(busy), 32'(cyc >= mon_g + 1 && cyc <= mon_g + FRAME + GAP_CYCLES));
            check_output("tx_data", 32'(tx_data), 32'(mon_byte));
            check_output("grant_id", 32'(grant_id), 32'(mon_id));
            if (due) begin
                mon_g    = cyc;
                mon_byte = cur.data;
                mon_id   = cur.id;
            end
            if (reset) begin
                mon_g    = -1000;
                mon_byte = '0;
                mon_id   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        req_valid = v;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[8*i +: 8] = d[i];
        end
    endtask

    // Advance n cycles acting as the requesters: an accepted byte is retired
    // unless in hold mode (continuously valid), and random traffic raises or
    // legally withdraws requests while keeping data stable while valid.
    task automatic apply_stimulus(input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accepted[i] && !hold) begin
                    v[i] = 1'b0;
                end
                if (rand_en) begin
                    if (!v[i]) begin
                        if ($urandom_range(0, 5) == 0) begin
                            v[i] = 1'b1;
                            d[i] = 8'($urandom);
                        end
                    end else if ($urandom_range(0, 63) == 0) begin
                        v[i] = 1'b0;
                    end
                end
            end
            drive();
        end
    endtask

    task automatic wait_accept(input int idx);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            apply_stimulus(1);
            got = accepted[idx];
        end
        check_output("accept_wait", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        v     = '0;
        drive();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d[i] = '0;
        end

        // reset held three cycles, then a long idle stretch
        repeat (3) tick();
        tick();
        reset = 1'b0;
        apply_stimulus(20);

        // single requester 2 with 0xAA
        v    = 4'b0100;
        d[2] = 8'hAA;
        drive();
        wait_accept(2);
        apply_stimulus(50);

        // all four continuously valid: 0,1,2,3,0 order
        do_reset();
        hold = 1'b1;
        v    = 4'b1111;
        d[0] = 8'h10;
        d[1] = 8'h21;
        d[2] = 8'h32;
        d[3] = 8'h43;
        drive();
        apply_stimulus(5 * PERIOD + 5);
        hold = 1'b0;
        v    = '0;
        drive();
        apply_stimulus(50);

        // after granting 1, requesters 1 and 3 pending: 3 must come next
        hold = 1'b1;
        v    = 4'b0010;
        d[1] = 8'h5A;
        d[3] = 8'hC3;
        drive();
        wait_accept(1);
        v = 4'b1010;
        drive();
        apply_stimulus(3 * PERIOD + 5);
        hold = 1'b0;
        v    = '0;
        drive();
        apply_stimulus(50);

        // reset in the middle of a frame, then requester 0 must win first
        v    = 4'b0001;
        d[0] = 8'h77;
        drive();
        wait_accept(0);
        apply_stimulus(19);
        do_reset();
        hold = 1'b1;
        v    = 4'b0011;
        d[0] = 8'h01;
        d[1] = 8'h02;
        drive();
        apply_stimulus(2 * PERIOD + 5);
        hold = 1'b0;
        v    = '0;
        drive();
        apply_stimulus(50);

        // requester 1 pulses during SEND and withdraws before IDLE
        v    = 4'b0001;
        d[0] = 8'h99;
        drive();
        wait_accept(0);
        apply_stimulus(10);
        v[1] = 1'b1;
        d[1] = 8'h66;
        drive();
        apply_stimulus(5);
        v[1] = 1'b0;
        drive();
        apply_stimulus(60);

        // randomized traffic, alternating retire and hold behaviour
        rand_en = 1'b1;
        for (int blk = 0; blk < 8; blk++) begin
            hold = 1'($urandom_range(0, 1));
            apply_stimulus(100);
        end
        rand_en = 1'b0;
        hold    = 1'b0;
        v       = '0;
        drive();
        apply_stimulus(PERIOD + 10);

        check_output("pending_grants", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
